// File: rtl/filtro_pkg.sv
// Shared definitions for the biquad sequencer: default widths, coefficient
// select codes presented to the external ROM, and the FSM state encoding.
package filtro_pkg;

    localparam int CANT_BITS = 25;
    localparam int FRAC_BITS = 14;

    // Coefficient ROM addresses; a1/a2 are stored pre-negated in the ROM.
    typedef enum logic [3:0] {
        SEL_UNO = 4'b0000,
        SEL_A1  = 4'b0001,
        SEL_A2  = 4'b0010,
        SEL_B0  = 4'b0101,
        SEL_B1  = 4'b0110,
        SEL_B2  = 4'b0111
    } sel_cte_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        M_B0   = 3'd1,
        M_B1   = 3'd2,
        M_B2   = 3'd3,
        M_A1   = 3'd4,
        M_A2   = 3'd5,
        SALIDA = 3'd6
    } estado_t;

    // Coefficient to fetch for the step that follows the given MAC step.
    function automatic sel_cte_t sel_siguiente(input estado_t estado);
        case (estado)
            M_B0:    sel_siguiente = SEL_B1;
            M_B1:    sel_siguiente = SEL_B2;
            M_B2:    sel_siguiente = SEL_A1;
            M_A1:    sel_siguiente = SEL_A2;
            default: sel_siguiente = SEL_UNO;
        endcase
    endfunction

endpackage

// File: rtl/saturador_trunc.sv
// Converts the wide accumulator back to sample format: arithmetic shift by
// the coefficient fraction (floor rounding) and clamp to the output range.
module saturador_trunc
    import filtro_pkg::*;
#(
    parameter int acc_bits  = 2 * CANT_BITS + 3,
    parameter int cant_bits = CANT_BITS,
    parameter int frac_bits = FRAC_BITS
) (
    input  logic signed [acc_bits-1:0]  acc,
    output logic signed [cant_bits-1:0] r
);

    logic signed [acc_bits-1:0] desplazado;

    // Clamp a shifted accumulator value into cant_bits two's complement.
    function automatic logic signed [cant_bits-1:0] recortar(input logic signed [acc_bits-1:0] v);
        logic [acc_bits-cant_bits:0] alto;
        alto = v[acc_bits-1:cant_bits-1];
        if ((&alto) || !(|alto)) begin
            recortar = v[cant_bits-1:0];
        end else if (v[acc_bits-1]) begin
            recortar = {1'b1, {(cant_bits-1){1'b0}}};
        end else begin
            recortar = {1'b0, {(cant_bits-1){1'b1}}};
        end
    endfunction

    // Shift drops the fraction toward -inf, then saturate.
    always_comb begin
        desplazado = acc >>> frac_bits;
        r          = recortar(desplazado);
    end

endmodule

// File: rtl/secuenciador_biquad.sv
// Biquad sequencer: one shared signed MAC walks b0,b1,b2,a1,a2 from the
// external coefficient ROM per sample tick, then saturates, updates the
// delay lines and pulses y_valid.
module secuenciador_biquad
    import filtro_pkg::*;
#(
    parameter int cant_bits = CANT_BITS,
    parameter int frac_bits = FRAC_BITS,
    parameter int acc_bits  = 2 * cant_bits + 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        tick,
    input  logic signed [cant_bits-1:0] x_in,
    input  logic                        limpiar,
    input  logic signed [cant_bits-1:0] cte,
    output logic [3:0]                  sel_cte,
    output logic signed [cant_bits-1:0] y_out,
    output logic                        y_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int PROD_BITS = 2 * cant_bits;

    estado_t  estado_q, estado_d;
    sel_cte_t sel_cte_q, sel_cte_d;

    logic signed [cant_bits-1:0] x0_q, x0_d;
    logic signed [cant_bits-1:0] x1_q, x1_d;
    logic signed [cant_bits-1:0] x2_q, x2_d;
    logic signed [cant_bits-1:0] y1_q, y1_d;
    logic signed [cant_bits-1:0] y2_q, y2_d;
    logic signed [cant_bits-1:0] y_out_q, y_out_d;
    logic signed [acc_bits-1:0]  acc_q, acc_d;
    logic                        y_valid_q, y_valid_d;
    logic                        overrun_q, overrun_d;

    logic signed [cant_bits-1:0] operando;
    logic signed [PROD_BITS-1:0] producto;
    logic signed [acc_bits-1:0]  producto_ext;
    logic signed [cant_bits-1:0] resultado;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

    // FSM next state: one MAC per state, limpiar always returns to IDLE.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:    if (tick) estado_d = M_B0;
            M_B0:    estado_d = M_B1;
            M_B1:    estado_d = M_B2;
            M_B2:    estado_d = M_A1;
            M_A1:    estado_d = M_A2;
            M_A2:    estado_d = SALIDA;
            SALIDA:  estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
        if (limpiar) begin
            estado_d = IDLE;
        end
    end

    // FSM outputs: busy flag and the delay-line sample paired with cte.
    always_comb begin
        busy     = (estado_q != IDLE);
        operando = '0;
        case (estado_q)
            M_B0:    operando = x0_q;
            M_B1:    operando = x1_q;
            M_B2:    operando = x2_q;
            M_A1:    operando = y1_q;
            M_A2:    operando = y2_q;
            default: operando = '0;
        endcase
    end

    // Full-precision product, sign-extended so the sum of five never overflows.
    assign producto     = cte * operando;
    assign producto_ext = {{(acc_bits-PROD_BITS){producto[PROD_BITS-1]}}, producto};

    saturador_trunc #(
        .acc_bits  (acc_bits),
        .cant_bits (cant_bits),
        .frac_bits (frac_bits)
    ) u_saturador (
        .acc (acc_q),
        .r   (resultado)
    );

    // Datapath next values: accumulate, commit result, or clear.
    always_comb begin
        x0_d      = x0_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        y1_d      = y1_q;
        y2_d      = y2_q;
        acc_d     = acc_q;
        y_out_d   = y_out_q;
        sel_cte_d = sel_cte_q;
        y_valid_d = 1'b0;
        overrun_d = tick && busy && !limpiar;

        case (estado_q)
            IDLE: begin
                sel_cte_d = SEL_UNO;
                if (tick) begin
                    x0_d      = x_in;
                    acc_d     = '0;
                    sel_cte_d = SEL_B0;
                end
            end
            M_B0, M_B1, M_B2, M_A1, M_A2: begin
                acc_d     = acc_q + producto_ext;
                sel_cte_d = sel_siguiente(estado_q);
            end
            SALIDA: begin
                y_out_d   = resultado;
                y_valid_d = 1'b1;
                x2_d      = x1_q;
                x1_d      = x0_q;
                y2_d      = y1_q;
                y1_d      = resultado;
                sel_cte_d = SEL_UNO;
            end
            default: sel_cte_d = SEL_UNO;
        endcase

        // limpiar wipes history and any in-flight sample; y_out keeps its value.
        if (limpiar) begin
            x0_d      = x0_q;
            x1_d      = '0;
            x2_d      = '0;
            y1_d      = '0;
            y2_d      = '0;
            acc_d     = '0;
            y_out_d   = y_out_q;
            y_valid_d = 1'b0;
            sel_cte_d = SEL_UNO;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            sel_cte_q <= SEL_UNO;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            acc_q     <= acc_d;
            y_out_q   <= y_out_d;
            sel_cte_q <= sel_cte_d;
            y_valid_q <= y_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sel_cte = sel_cte_q;
    assign y_out   = y_out_q;
    assign y_valid = y_valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_secuenciador_biquad.sv
// Directed bench for secuenciador_biquad with a 20 kHz low-pass ROM model
// (b0=b2=0x340B, b1=0x6816, -a1=-26074, -a2=-10834) and a saturation ROM.
module tb_secuenciador_biquad;

    localparam int W = 25;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic                tick = 1'b0;
    logic                limpiar = 1'b0;
    logic signed [W-1:0] x_in = '0;
    logic signed [W-1:0] cte;
    logic [3:0]          sel_cte;
    logic signed [W-1:0] y_out;
    logic                y_valid;
    logic                busy;
    logic                overrun;
    logic                modo_sat = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Coefficient ROM model.
    always_comb begin
        cte = '0;
        if (modo_sat) begin
            if (sel_cte == 4'b0101) cte = 25'sh0FFFFFF;
        end else begin
            case (sel_cte)
                4'b0000: cte = 25'sd16384;
                4'b0101: cte = 25'sd13323;
                4'b0110: cte = 25'sd26646;
                4'b0111: cte = 25'sd13323;
                4'b0001: cte = -25'sd26074;
                4'b0010: cte = -25'sd10834;
                default: cte = '0;
            endcase
        end
    end

    secuenciador_biquad #(.cant_bits(25), .frac_bits(14), .acc_bits(53)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .x_in    (x_in),
        .limpiar (limpiar),
        .cte     (cte),
        .sel_cte (sel_cte),
        .y_out   (y_out),
        .y_valid (y_valid),
        .busy    (busy),
        .overrun (overrun)
    );

    // Issue one tick at the current negedge and observe `window` cycles.
    task automatic run_tick(input logic signed [W-1:0] x, input int tick2_at, input int clr_at,
                            input int window, output int nvalid, output int lat,
                            output logic signed [W-1:0] y, output logic [19:0] sels,
                            output logic [19:0] busy_seq, output int novr);
        nvalid = 0; lat = 0; y = '0; sels = '0; busy_seq = '0; novr = 0;
        tick = 1'b1; x_in = x; limpiar = 1'b0;
        for (int k = 1; k <= window; k++) begin
            @(negedge clk);
            if (y_valid) begin
                nvalid++;
                if (lat == 0) lat = k;
                y = y_out;
            end
            if (overrun) novr++;
            if (k <= 5) sels[(k-1)*4 +: 4] = sel_cte;
            if (k <= 20) busy_seq[k-1] = busy;
            tick = (k == tick2_at);
            limpiar = (k == clr_at);
            if (k == tick2_at) x_in = 25'sh0AAAAA;
        end
        tick = 1'b0; limpiar = 1'b0;
    endtask

    task automatic pulse_limpiar();
        limpiar = 1'b1;
        @(negedge clk);
        limpiar = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #2;
        checks++; if (sel_cte !== 4'b0000) begin errors++; $display("FAIL reset_sel: got %b expected 0000", sel_cte); end
        checks++; if (y_out !== 25'h0) begin errors++; $display("FAIL reset_y: got %h expected 0", y_out); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", y_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        int nv, lat, novr; logic signed [W-1:0] y; logic [19:0] s, b;
        run_tick(25'sh4000, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh00340B) begin errors++; $display("FAIL impulse_y0: got %h expected 00340b", y); end
        checks++; if (lat != 7) begin errors++; $display("FAIL impulse_lat0: got %0d expected 7", lat); end
        checks++; if (nv != 1) begin errors++; $display("FAIL impulse_nvalid0: got %0d expected 1", nv); end
        checks++; if (b[9:0] !== 10'b0000111111) begin errors++; $display("FAIL impulse_busy: got %b expected 0000111111", b[9:0]); end
        run_tick(25'sh0, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh001543) begin errors++; $display("FAIL impulse_y1: got %h expected 001543", y); end
        checks++; if (lat != 7) begin errors++; $display("FAIL impulse_lat1: got %0d expected 7", lat); end
    endtask

    task automatic test_limpiar_idle();
        int nv, lat, novr; logic signed [W-1:0] y; logic [19:0] s, b;
        pulse_limpiar();
        checks++; if (y_out !== 25'sh001543) begin errors++; $display("FAIL limpiar_idle_hold: got %h expected 001543", y_out); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL limpiar_idle_valid: got %b expected 0", y_valid); end
        run_tick(25'sh0, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh0) begin errors++; $display("FAIL limpiar_idle_cleared: got %h expected 0", y); end
    endtask

    task automatic test_back_to_back();
        int nv, lat, novr; logic signed [W-1:0] y; logic [19:0] s, b;
        pulse_limpiar();
        run_tick(25'sh4000, 0, 0, 7, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh00340B || lat != 7) begin errors++; $display("FAIL b2b_y0: got %h lat %0d expected 00340b lat 7", y, lat); end
        run_tick(25'sh0, 0, 0, 7, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh001543 || lat != 7) begin errors++; $display("FAIL b2b_y1: got %h lat %0d expected 001543 lat 7", y, lat); end
        checks++; if (novr != 0) begin errors++; $display("FAIL b2b_overrun: got %0d expected 0", novr); end
    endtask

    task automatic test_dc_step();
        int nv, lat, novr; logic signed [W-1:0] y; logic [19:0] s, b; int diff;
        pulse_limpiar();
        for (int n = 0; n < 200; n++) begin
            run_tick(25'sh4000, 0, 0, 10, nv, lat, y, s, b, novr);
            checks++;
            if (s !== 20'h21765) begin errors++; $display("FAIL dc_sel_seq[%0d]: got %h expected 21765", n, s); end
        end
        diff = int'(y) - 16384;
        checks++; if (diff < -4 || diff > 4) begin errors++; $display("FAIL dc_final: got %h expected 004000 +-4", y); end
    endtask

    task automatic test_overrun();
        int nv, lat, novr; logic signed [W-1:0] y; logic [19:0] s, b;
        pulse_limpiar();
        run_tick(25'sh4000, 3, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (novr != 1) begin errors++; $display("FAIL overrun_pulses: got %0d expected 1", novr); end
        checks++; if (nv != 1) begin errors++; $display("FAIL overrun_nvalid: got %0d expected 1", nv); end
        checks++; if (y !== 25'sh00340B) begin errors++; $display("FAIL overrun_y0: got %h expected 00340b", y); end
        run_tick(25'sh0, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh001543) begin errors++; $display("FAIL overrun_y1: got %h expected 001543", y); end
    endtask

    task automatic test_limpiar_busy();
        int nv, lat, novr; logic signed [W-1:0] y; logic [19:0] s, b;
        pulse_limpiar();
        run_tick(25'sh4000, 0, 3, 10, nv, lat, y, s, b, novr);
        checks++; if (nv != 0) begin errors++; $display("FAIL abort_nvalid: got %0d expected 0", nv); end
        checks++; if (b[3:0] !== 4'b0111) begin errors++; $display("FAIL abort_busy: got %b expected 0111", b[3:0]); end
        run_tick(25'sh4000, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh00340B) begin errors++; $display("FAIL abort_y0: got %h expected 00340b", y); end
        run_tick(25'sh0, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh001543) begin errors++; $display("FAIL abort_y1: got %h expected 001543", y); end
    endtask

    task automatic test_limpiar_tick();
        int nv, lat, novr, cnt; logic signed [W-1:0] y; logic [19:0] s, b;
        tick = 1'b1; limpiar = 1'b1; x_in = 25'sh4000;
        @(negedge clk);
        tick = 1'b0; limpiar = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_tick_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_tick_overrun: got %b expected 0", overrun); end
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (y_valid) cnt++;
        end
        checks++; if (cnt != 0) begin errors++; $display("FAIL clr_tick_valid: got %0d expected 0", cnt); end
        run_tick(25'sh4000, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh00340B) begin errors++; $display("FAIL clr_tick_y0: got %h expected 00340b", y); end
    endtask

    task automatic test_saturation();
        int nv, lat, novr; logic signed [W-1:0] y; logic [19:0] s, b;
        modo_sat = 1'b1;
        run_tick(25'sh0FFFFFF, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh0FFFFFF) begin errors++; $display("FAIL sat_pos: got %h expected 0ffffff", y); end
        run_tick(25'sh1000000, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh1000000) begin errors++; $display("FAIL sat_neg: got %h expected 1000000", y); end
        run_tick(25'sd16, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh0003FFF) begin errors++; $display("FAIL trunc_pos: got %h expected 0003fff", y); end
        run_tick(-25'sd16, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh1FFC000) begin errors++; $display("FAIL trunc_neg: got %h expected 1ffc000", y); end
        modo_sat = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nv, lat, novr, cnt; logic signed [W-1:0] y; logic [19:0] s, b;
        tick = 1'b1; x_in = 25'sh4000;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (sel_cte !== 4'b0000) begin errors++; $display("FAIL mid_sel: got %b expected 0000", sel_cte); end
        checks++; if (y_out !== 25'h0) begin errors++; $display("FAIL mid_y: got %h expected 0", y_out); end
        checks++; if (y_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_pulses: got %b%b expected 00", y_valid, overrun); end
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (y_valid) cnt++;
        end
        checks++; if (cnt != 0) begin errors++; $display("FAIL mid_valid: got %0d expected 0", cnt); end
        run_tick(25'sh4000, 0, 0, 10, nv, lat, y, s, b, novr);
        checks++; if (y !== 25'sh00340B) begin errors++; $display("FAIL mid_after_y: got %h expected 00340b", y); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_limpiar_idle();
        test_back_to_back();
        test_dc_step();
        test_overrun();
        test_limpiar_busy();
        test_limpiar_tick();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
